// File: rtl/cp0_pkg.sv
// cp0_pkg: shared constants for the coprocessor-0 slice.
//   - ExcCode values carried in cause_in[3:2]
//   - CP0 register numbers for Status, Cause and EPC
//   - selpc and mfc0 select encodings
package cp0_pkg;

    typedef enum logic [1:0] {
        EXC_INT = 2'b00,
        EXC_SYS = 2'b01,
        EXC_UNI = 2'b10,
        EXC_OVR = 2'b11
    } exc_code_e;

    localparam int unsigned CP0_REG_STATUS = 12;
    localparam int unsigned CP0_REG_CAUSE  = 13;
    localparam int unsigned CP0_REG_EPC    = 14;

    typedef enum logic [1:0] {
        SELPC_NPC = 2'b00,
        SELPC_EPC = 2'b01,
        SELPC_EXC = 2'b10
    } selpc_e;

    typedef enum logic [1:0] {
        MFC0_WB  = 2'b00,
        MFC0_STA = 2'b01,
        MFC0_CAU = 2'b10,
        MFC0_EPC = 2'b11
    } mfc0_e;

endpackage

// File: rtl/cp0_regs_if.sv
// cp0_regs_if: bundle between the interrupt-aware control decoder / datapath
// (master) and the CP0 register block (slave).
//   master drives: intr_in, inta, exc, wsta, wcau, wepc, mtc0, mfc0, selpc,
//                  cause_in, rt_data, pc, npc, wb_data
//   slave drives:  intr, sta, cau, epc, c0_rdata, next_pc
interface cp0_regs_if;
    logic        intr_in;
    logic        intr;
    logic        inta;
    logic        exc;
    logic        wsta;
    logic        wcau;
    logic        wepc;
    logic        mtc0;
    logic [1:0]  mfc0;
    logic [1:0]  selpc;
    logic [31:0] cause_in;
    logic [31:0] rt_data;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] wb_data;
    logic [31:0] sta;
    logic [31:0] cau;
    logic [31:0] epc;
    logic [31:0] c0_rdata;
    logic [31:0] next_pc;

    modport master (
        output intr_in, inta, exc, wsta, wcau, wepc, mtc0, mfc0, selpc,
               cause_in, rt_data, pc, npc, wb_data,
        input  intr, sta, cau, epc, c0_rdata, next_pc
    );

    modport slave (
        input  intr_in, inta, exc, wsta, wcau, wepc, mtc0, mfc0, selpc,
               cause_in, rt_data, pc, npc, wb_data,
        output intr, sta, cau, epc, c0_rdata, next_pc
    );
endinterface

// File: rtl/intr_sync.sv
// intr_sync: brings the raw external interrupt level into the clock domain,
// detects its rising edge and holds it as a pending request until acknowledged.
//   clk, rst  : clock, asynchronous active-high reset
//   intr_in   : raw asynchronous interrupt level
//   inta      : acknowledge, clears the pending request
//   intr      : pending request
module intr_sync #(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic clk,
    input  logic rst,
    input  logic intr_in,
    input  logic inta,
    output logic intr
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   pend_q;
    logic                   pend_d;
    logic                   rise;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], intr_in};
    assign rise   = sync_q[SYNC_STAGES-1] & ~prev_q;
    // A new edge wins over a simultaneous acknowledge so no request is lost.
    assign pend_d = rise | (pend_q & ~inta);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
            pend_q <= pend_d;
        end
    end

    assign intr = pend_q;

endmodule

// File: rtl/cp0_regs.sv
// cp0_regs: Status / Cause / EPC registers, interrupt request latch,
// next-PC select and mfc0 read mux.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : cp0_regs_if.slave (decoder controls, datapath values, CP0 outputs)
// Status holds an 8-deep stack of 4-bit interrupt masks: an exception pushes
// a zero nibble at the bottom, eret pops it.
module cp0_regs
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_BASE    = 32'h0000_0008,
    parameter int          SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    cp0_regs_if.slave     bus
);

    logic [31:0] sta_q, sta_d;
    logic [31:0] cau_q, cau_d;
    logic [31:0] epc_q, epc_d;
    logic        intr_w;
    logic        eret;

    assign eret = bus.wsta && (bus.selpc == SELPC_EPC);

    always_comb begin
        sta_d = sta_q;
        if (bus.exc) begin
            sta_d = {sta_q[27:0], 4'b0000};
        end else if (eret) begin
            sta_d = {4'b0000, sta_q[31:4]};
        end else if (bus.wsta && bus.mtc0) begin
            sta_d = bus.rt_data;
        end
    end

    always_comb begin
        cau_d = cau_q;
        if (bus.exc) begin
            cau_d = bus.cause_in;
        end else if (bus.wcau && bus.mtc0) begin
            cau_d = bus.rt_data;
        end
    end

    // Faults (unimplemented, overflow) save the faulting pc so it can be
    // re-executed; interrupts and syscalls resume at the following instruction.
    always_comb begin
        epc_d = epc_q;
        if (bus.exc) begin
            case (bus.cause_in[3:2])
                EXC_INT, EXC_SYS: epc_d = bus.npc;
                default:          epc_d = bus.pc;
            endcase
        end else if (bus.wepc && bus.mtc0) begin
            epc_d = bus.rt_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sta_q <= '0;
            cau_q <= '0;
            epc_q <= '0;
        end else begin
            sta_q <= sta_d;
            cau_q <= cau_d;
            epc_q <= epc_d;
        end
    end

    intr_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_intr_sync (
        .clk     (clk),
        .rst     (rst),
        .intr_in (bus.intr_in),
        .inta    (bus.inta),
        .intr    (intr_w)
    );

    // Read paths see the register values before this cycle's update.
    always_comb begin
        case (bus.mfc0)
            MFC0_STA: bus.c0_rdata = sta_q;
            MFC0_CAU: bus.c0_rdata = cau_q;
            MFC0_EPC: bus.c0_rdata = epc_q;
            default:  bus.c0_rdata = bus.wb_data;
        endcase
    end

    always_comb begin
        case (bus.selpc)
            SELPC_NPC: bus.next_pc = bus.npc;
            SELPC_EPC: bus.next_pc = epc_q;
            default:   bus.next_pc = EXC_BASE;
        endcase
    end

    assign bus.intr = intr_w;
    assign bus.sta  = sta_q;
    assign bus.cau  = cau_q;
    assign bus.epc  = epc_q;

endmodule

// File: tb/tb_cp0_regs.sv
// tb_cp0_regs: directed scenarios plus randomized traffic for cp0_regs,
// checked against a behavioural model (Status as an array of mask nibbles,
// interrupt as a history of sampled input levels).
module tb_cp0_regs;
    import cp0_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cp0_regs_if bus ();

    cp0_regs #(
        .EXC_BASE    (32'h0000_0008),
        .SYNC_STAGES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state
    logic [3:0]  m_stk [8];   // m_stk[0] is the active mask nibble
    logic [31:0] m_cau;
    logic [31:0] m_epc;
    logic        m_h [3];     // intr_in sampled at the last three edges, newest first
    logic        m_pend;

    function automatic logic [31:0] m_sta();
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) r = r | (32'(m_stk[i]) << (4 * i));
        return r;
    endfunction

    function automatic logic [31:0] exp_rdata();
        case (bus.mfc0)
            2'd1:    return m_sta();
            2'd2:    return m_cau;
            2'd3:    return m_epc;
            default: return bus.wb_data;
        endcase
    endfunction

    function automatic logic [31:0] exp_npc();
        if (bus.selpc[1]) return 32'h8;
        if (bus.selpc[0]) return m_epc;
        return bus.npc;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_stk[i] = 4'h0;
        m_cau  = '0;
        m_epc  = '0;
        for (int i = 0; i < 3; i++) m_h[i] = 1'b0;
        m_pend = 1'b0;
    endtask

    task automatic idle();
        bus.intr_in  = 1'b0; bus.inta = 1'b0; bus.exc = 1'b0;
        bus.wsta = 1'b0; bus.wcau = 1'b0; bus.wepc = 1'b0; bus.mtc0 = 1'b0;
        bus.mfc0 = 2'd0; bus.selpc = 2'd0;
        bus.cause_in = '0; bus.rt_data = '0;
        bus.pc = 32'h1000; bus.npc = 32'h1004; bus.wb_data = 32'h5A5A_0001;
    endtask

    // Advance one clock edge and move the model to its post-edge state.
    task automatic tick();
        logic [3:0]  nstk [8];
        logic [31:0] ncau, nepc;
        logic        npend;
        for (int i = 0; i < 8; i++) nstk[i] = m_stk[i];
        ncau = m_cau;
        nepc = m_epc;
        if (bus.exc) begin
            for (int i = 7; i > 0; i--) nstk[i] = m_stk[i-1];
            nstk[0] = 4'h0;
        end else if (bus.wsta && bus.selpc == 2'd1) begin
            for (int i = 0; i < 7; i++) nstk[i] = m_stk[i+1];
            nstk[7] = 4'h0;
        end else if (bus.wsta && bus.mtc0) begin
            for (int i = 0; i < 8; i++) nstk[i] = bus.rt_data[4*i +: 4];
        end
        if (bus.exc) ncau = bus.cause_in;
        else if (bus.wcau && bus.mtc0) ncau = bus.rt_data;
        if (bus.exc) nepc = bus.cause_in[3] ? bus.pc : bus.npc;
        else if (bus.wepc && bus.mtc0) nepc = bus.rt_data;
        // The level seen two edges ago rose relative to three edges ago.
        npend = (m_h[1] & ~m_h[2]) | (m_pend & ~bus.inta);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 8; i++) m_stk[i] = nstk[i];
            m_cau  = ncau;
            m_epc  = nepc;
            m_pend = npend;
            m_h[2] = m_h[1];
            m_h[1] = m_h[0];
            m_h[0] = bus.intr_in;
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        total++; if (bus.sta !== 32'h0) begin bad++; $display("FAIL reset_sta got=%h want=%h", bus.sta, 32'h0); end
        total++; if (bus.cau !== 32'h0) begin bad++; $display("FAIL reset_cau got=%h want=%h", bus.cau, 32'h0); end
        total++; if (bus.epc !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h want=%h", bus.epc, 32'h0); end
        total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL reset_intr got=%b want=0", bus.intr); end
        total++; if (bus.next_pc !== 32'h1004) begin bad++; $display("FAIL reset_next_pc got=%h want=%h", bus.next_pc, 32'h1004); end
        total++; if (bus.c0_rdata !== 32'h5A5A_0001) begin bad++; $display("FAIL reset_rdata got=%h want=%h", bus.c0_rdata, 32'h5A5A_0001); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mtc0_status();
        idle();
        bus.rt_data = 32'h0000_000F; bus.mtc0 = 1'b1; bus.wsta = 1'b1; bus.mfc0 = 2'd1;
        #1;
        total++; if (bus.c0_rdata !== 32'h0) begin bad++; $display("FAIL mtc0_old_read got=%h want=%h", bus.c0_rdata, 32'h0); end
        tick();
        total++; if (bus.sta !== 32'h0000_000F) begin bad++; $display("FAIL mtc0_sta got=%h want=%h", bus.sta, 32'hF); end
        idle();
    endtask

    task automatic test_overflow_exc();
        idle();
        bus.exc = 1'b1; bus.cause_in = 32'h0000_000C; bus.pc = 32'h100; bus.npc = 32'h104; bus.selpc = 2'b10;
        #1;
        total++; if (bus.next_pc !== 32'h8) begin bad++; $display("FAIL ovf_next_pc got=%h want=%h", bus.next_pc, 32'h8); end
        tick();
        total++; if (bus.sta !== 32'hF0) begin bad++; $display("FAIL ovf_sta got=%h want=%h", bus.sta, 32'hF0); end
        total++; if (bus.cau !== 32'hC) begin bad++; $display("FAIL ovf_cau got=%h want=%h", bus.cau, 32'hC); end
        total++; if (bus.epc !== 32'h100) begin bad++; $display("FAIL ovf_epc got=%h want=%h", bus.epc, 32'h100); end
        idle();
    endtask

    task automatic test_eret();
        idle();
        bus.selpc = 2'b01; bus.wsta = 1'b1;
        #1;
        total++; if (bus.next_pc !== 32'h100) begin bad++; $display("FAIL eret_next_pc got=%h want=%h", bus.next_pc, 32'h100); end
        tick();
        total++; if (bus.sta !== 32'h0F) begin bad++; $display("FAIL eret_sta got=%h want=%h", bus.sta, 32'h0F); end
        idle();
    endtask

    task automatic test_syscall_epc();
        idle();
        bus.exc = 1'b1; bus.cause_in = 32'h4; bus.pc = 32'h200; bus.npc = 32'h204; bus.selpc = 2'b10;
        tick();
        total++; if (bus.epc !== 32'h204) begin bad++; $display("FAIL sys_epc got=%h want=%h", bus.epc, 32'h204); end
        total++; if (bus.cau !== 32'h4) begin bad++; $display("FAIL sys_cau got=%h want=%h", bus.cau, 32'h4); end
        idle();
    endtask

    task automatic test_ignored_writes();
        logic [31:0] s0, c0, e0;
        idle();
        s0 = bus.sta; c0 = bus.cau; e0 = bus.epc;
        bus.wsta = 1'b1; bus.wcau = 1'b1; bus.wepc = 1'b1; bus.rt_data = 32'hDEAD_BEEF;
        tick();
        total++; if (bus.sta !== s0) begin bad++; $display("FAIL ign_sta got=%h want=%h", bus.sta, s0); end
        total++; if (bus.cau !== c0) begin bad++; $display("FAIL ign_cau got=%h want=%h", bus.cau, c0); end
        total++; if (bus.epc !== e0) begin bad++; $display("FAIL ign_epc got=%h want=%h", bus.epc, e0); end
        idle();
    endtask

    task automatic test_stack_depth();
        idle();
        bus.mtc0 = 1'b1; bus.wsta = 1'b1; bus.rt_data = 32'h8765_4321;
        tick();
        idle();
        bus.exc = 1'b1;
        tick();
        total++; if (bus.sta !== 32'h7654_3210) begin bad++; $display("FAIL push1_sta got=%h want=%h", bus.sta, 32'h7654_3210); end
        for (int i = 0; i < 8; i++) tick();
        total++; if (bus.sta !== 32'h0) begin bad++; $display("FAIL push9_sta got=%h want=%h", bus.sta, 32'h0); end
        idle();
        bus.mtc0 = 1'b1; bus.wsta = 1'b1; bus.rt_data = 32'h8765_4321;
        tick();
        idle();
        bus.wsta = 1'b1; bus.selpc = 2'b01;
        tick();
        total++; if (bus.sta !== 32'h0876_5432) begin bad++; $display("FAIL pop1_sta got=%h want=%h", bus.sta, 32'h0876_5432); end
        for (int i = 0; i < 8; i++) tick();
        total++; if (bus.sta !== 32'h0) begin bad++; $display("FAIL pop9_sta got=%h want=%h", bus.sta, 32'h0); end
        total++; if (bus.sta !== m_sta()) begin bad++; $display("FAIL stack_model got=%h want=%h", bus.sta, m_sta()); end
        idle();
    endtask

    task automatic test_interrupt();
        idle();
        for (int i = 0; i < 4; i++) tick();
        bus.intr_in = 1'b1;
        tick();
        total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL irq_edge1 got=%b want=0", bus.intr); end
        tick();
        total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL irq_edge2 got=%b want=0", bus.intr); end
        tick();
        total++; if (bus.intr !== 1'b1) begin bad++; $display("FAIL irq_edge3 got=%b want=1", bus.intr); end
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL irq_ack got=%b want=0", bus.intr); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL irq_held_high got=%b want=0", bus.intr); end
        end
        bus.intr_in = 1'b0;
        tick(); tick(); tick();
        bus.intr_in = 1'b1;
        tick(); tick();
        bus.inta = 1'b1;
        tick();
        bus.inta = 1'b0;
        total++; if (bus.intr !== 1'b1) begin bad++; $display("FAIL irq_set_wins got=%b want=1", bus.intr); end
        total++; if (bus.intr !== m_pend) begin bad++; $display("FAIL irq_model got=%b want=%b", bus.intr, m_pend); end
    endtask

    task automatic test_async_reset();
        idle();
        bus.mtc0 = 1'b1; bus.wsta = 1'b1; bus.wcau = 1'b1; bus.wepc = 1'b1; bus.rt_data = 32'h1234_5678;
        bus.intr_in = 1'b1;
        tick();
        idle();
        bus.intr_in = 1'b1;
        bus.selpc = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        total++; if (bus.sta !== 32'h0) begin bad++; $display("FAIL arst_sta got=%h want=%h", bus.sta, 32'h0); end
        total++; if (bus.cau !== 32'h0) begin bad++; $display("FAIL arst_cau got=%h want=%h", bus.cau, 32'h0); end
        total++; if (bus.epc !== 32'h0) begin bad++; $display("FAIL arst_epc got=%h want=%h", bus.epc, 32'h0); end
        total++; if (bus.intr !== 1'b0) begin bad++; $display("FAIL arst_intr got=%b want=0", bus.intr); end
        total++; if (bus.next_pc !== 32'h0) begin bad++; $display("FAIL arst_next_pc_epc got=%h want=%h", bus.next_pc, 32'h0); end
        bus.selpc = 2'b00;
        #1;
        total++; if (bus.next_pc !== bus.npc) begin bad++; $display("FAIL arst_next_pc got=%h want=%h", bus.next_pc, bus.npc); end
        tick();
        rst = 1'b0;
        idle();
        tick();
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 400; n++) begin
            bus.exc      = ($urandom_range(0, 7) == 0);
            bus.wsta     = $urandom_range(0, 1) == 1;
            bus.wcau     = $urandom_range(0, 1) == 1;
            bus.wepc     = $urandom_range(0, 1) == 1;
            bus.mtc0     = $urandom_range(0, 1) == 1;
            bus.mfc0     = 2'($urandom_range(0, 3));
            bus.selpc    = 2'($urandom_range(0, 3));
            bus.cause_in = $urandom;
            bus.rt_data  = $urandom;
            bus.pc       = $urandom;
            bus.npc      = $urandom;
            bus.wb_data  = $urandom;
            bus.inta     = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) bus.intr_in = ~bus.intr_in;
            #1;
            total++; if (bus.c0_rdata !== exp_rdata()) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h want=%h", n, bus.c0_rdata, exp_rdata()); end
            total++; if (bus.next_pc !== exp_npc()) begin bad++; $display("FAIL rnd_next_pc n=%0d got=%h want=%h", n, bus.next_pc, exp_npc()); end
            tick();
            total++; if (bus.sta !== m_sta()) begin bad++; $display("FAIL rnd_sta n=%0d got=%h want=%h", n, bus.sta, m_sta()); end
            total++; if (bus.cau !== m_cau) begin bad++; $display("FAIL rnd_cau n=%0d got=%h want=%h", n, bus.cau, m_cau); end
            total++; if (bus.epc !== m_epc) begin bad++; $display("FAIL rnd_epc n=%0d got=%h want=%h", n, bus.epc, m_epc); end
            total++; if (bus.intr !== m_pend) begin bad++; $display("FAIL rnd_intr n=%0d got=%b want=%b", n, bus.intr, m_pend); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_mtc0_status();
        test_overflow_exc();
        test_eret();
        test_syscall_epc();
        test_ignored_writes();
        test_stack_depth();
        test_interrupt();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
